// File: rtl/apb_pkg.sv
// Shared APB master definitions: FSM state encoding and default widths.
// Both the APB master and the CPU stage that drives it use these values.
package apb_pkg;

  localparam int APB_ADDR_W  = 8;
  localparam int APB_DATA_W  = 21;
  localparam int APB_SEL_W   = 8;
  localparam int APB_TIMEOUT = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } apb_state_t;

endpackage

// File: rtl/apb_timeout_counter.sv
// ACCESS-phase wait counter. It counts the cycles in which the slave holds
// PREADY low. 'expired' is raised in the cycle whose increment brings the
// count to TIMEOUT, so the FSM leaves ACCESS after exactly TIMEOUT waits.
module apb_timeout_counter import apb_pkg::*; #(
  parameter int TIMEOUT = APB_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt;

  // The cycle that would complete the TIMEOUT-th wait is the expiry cycle.
  assign expired = enable && (cnt == CNT_W'(TIMEOUT - 1));

  // Wait counter: clear has priority, otherwise count one per wait cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && (cnt != CNT_W'(TIMEOUT))) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/apb_master.sv
// APB master bridging one-shot CPU requests onto an APB bus.
// IDLE -> SETUP -> ACCESS (waits on PREADY, bounded by TIMEOUT) -> DONE.
// All bus and CPU outputs are registered; PADDR/PWRITE/PWDATA act as the
// request latch and stay stable from SETUP through DONE.
module apb_master import apb_pkg::*; #(
  parameter int ADDR_W  = APB_ADDR_W,
  parameter int DATA_W  = APB_DATA_W,
  parameter int SEL_W   = APB_SEL_W,
  parameter int TIMEOUT = APB_TIMEOUT
) (
  input  logic              clk,
  input  logic              APBRESET,
  // CPU side
  input  logic              APBMASTERENABLE,
  input  logic              CPUWRITE,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data,
  input  logic [SEL_W-1:0]  CPUSEL,
  output logic              CPUPREADY,
  output logic [DATA_W-1:0] CPURDATA,
  output logic              CPUERR,
  // APB bus side
  output logic [SEL_W-1:0]  PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR
);

  apb_state_t state;
  logic       wait_clear;
  logic       wait_en;
  logic       wait_expired;

  // A usable select has exactly one bit set; zero or multiple bits are rejected.
  function automatic logic sel_is_onehot(input logic [SEL_W-1:0] v);
    return (v != '0) && ((v & (v - 1'b1)) == '0);
  endfunction

  // Counter restarts outside ACCESS and counts only the slave's wait cycles.
  assign wait_clear = (state != ACCESS);
  assign wait_en    = (state == ACCESS) && !PREADY;

  apb_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .rst     (APBRESET),
    .clear   (wait_clear),
    .enable  (wait_en),
    .expired (wait_expired)
  );

  // Transfer FSM with registered bus and CPU outputs.
  always_ff @(posedge clk or posedge APBRESET) begin
    if (APBRESET) begin
      state     <= IDLE;
      PSEL      <= '0;
      PENABLE   <= 1'b0;
      PWRITE    <= 1'b0;
      PADDR     <= '0;
      PWDATA    <= '0;
      CPUPREADY <= 1'b0;
      CPURDATA  <= '0;
      CPUERR    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          CPUPREADY <= 1'b0;
          PENABLE   <= 1'b0;
          if (APBMASTERENABLE) begin
            if (sel_is_onehot(CPUSEL)) begin
              PSEL   <= CPUSEL;
              PADDR  <= addr;
              PWDATA <= data;
              PWRITE <= CPUWRITE;
              state  <= SETUP;
            end else begin
              // Bad select: answer the CPU with an error, never touch the bus.
              PSEL      <= '0;
              CPUPREADY <= 1'b1;
              CPUERR    <= 1'b1;
              CPURDATA  <= '0;
              state     <= DONE;
            end
          end
        end

        SETUP: begin
          PENABLE <= 1'b1;
          state   <= ACCESS;
        end

        ACCESS: begin
          if (PREADY) begin
            PSEL      <= '0;
            PENABLE   <= 1'b0;
            CPUPREADY <= 1'b1;
            CPUERR    <= PSLVERR;
            if (!PWRITE) begin
              CPURDATA <= PRDATA;
            end
            state <= DONE;
          end else if (wait_expired) begin
            // Slave never answered: release the bus and report an error.
            PSEL      <= '0;
            PENABLE   <= 1'b0;
            CPUPREADY <= 1'b1;
            CPUERR    <= 1'b1;
            CPURDATA  <= '0;
            state     <= DONE;
          end
        end

        DONE: begin
          PSEL      <= '0;
          PENABLE   <= 1'b0;
          CPUPREADY <= 1'b0;
          CPUERR    <= 1'b0;
          state     <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master. The stimulus process pushes the expected
// CPU response for every request; a separate monitor pops it on each
// CPUPREADY pulse. Bus timing is checked inside the request task.
module tb_apb_master;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 21;
  localparam int SEL_W  = 8;

  typedef struct {
    logic [DATA_W-1:0] rd;
    logic              err;
  } exp_t;

  logic              clk = 1'b0;
  logic              APBRESET;
  logic              APBMASTERENABLE;
  logic              CPUWRITE;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data;
  logic [SEL_W-1:0]  CPUSEL;
  logic              CPUPREADY;
  logic [DATA_W-1:0] CPURDATA;
  logic              CPUERR;
  logic [SEL_W-1:0]  PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [ADDR_W-1:0] PADDR;
  logic [DATA_W-1:0] PWDATA;
  logic [DATA_W-1:0] PRDATA;
  logic              PREADY;
  logic              PSLVERR;

  int n_cmp = 0;
  int n_err = 0;
  exp_t sb[$];

  // slave model controls: PREADY rises after slv_delay wait cycles (-1 = never)
  int                slv_delay = 0;
  int                wcnt = 0;
  logic [DATA_W-1:0] slv_rdata = '0;
  logic              slv_err = 1'b0;

  // next request presented while the current one is in DONE
  logic              nx_wr;
  logic [ADDR_W-1:0] nx_addr;
  logic [DATA_W-1:0] nx_data;
  logic [SEL_W-1:0]  nx_sel;

  apb_master dut (
    .clk             (clk),
    .APBRESET        (APBRESET),
    .APBMASTERENABLE (APBMASTERENABLE),
    .CPUWRITE        (CPUWRITE),
    .addr            (addr),
    .data            (data),
    .CPUSEL          (CPUSEL),
    .CPUPREADY       (CPUPREADY),
    .CPURDATA        (CPURDATA),
    .CPUERR          (CPUERR),
    .PSEL            (PSEL),
    .PENABLE         (PENABLE),
    .PWRITE          (PWRITE),
    .PADDR           (PADDR),
    .PWDATA          (PWDATA),
    .PRDATA          (PRDATA),
    .PREADY          (PREADY),
    .PSLVERR         (PSLVERR)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end, got running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // slave: PREADY driven away from the rising edge, based on ACCESS cycles seen
  always @(negedge clk) begin
    PRDATA  = slv_rdata;
    PSLVERR = slv_err;
    if (PENABLE && (PSEL != '0)) begin
      PREADY = (slv_delay >= 0) && (wcnt == slv_delay);
      wcnt++;
    end else begin
      PREADY = 1'b0;
      wcnt   = 0;
    end
  end

  // monitor: every CPUPREADY pulse must match the oldest expectation
  always @(negedge clk) begin
    exp_t e;
    if (CPUPREADY === 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_cpupready: got 1 expected 0 at %0t", $time);
      end else begin
        e = sb.pop_front();
        check("cpurdata", CPURDATA, e.rd);
        check("cpuerr", CPUERR, e.err);
      end
    end
  end

  // One CPU request. Called at a falling edge with the DUT in IDLE.
  // exp_done: cycle of CPUPREADY counting the request cycle as 1.
  // exp_pen: PENABLE-high cycles; 0 means no bus activity at all.
  task automatic do_xfer(input logic wr, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d, input logic [SEL_W-1:0] sel,
                         input int dly, input logic [DATA_W-1:0] rd, input logic serr,
                         input logic [DATA_W-1:0] exp_rd, input logic exp_err,
                         input int exp_done, input int exp_pen, input bit keep);
    exp_t e;
    bit   seen = 0;
    bit   viol = 0;
    bit   anysel = 0;
    bit   valid;
    int   pen = 0;
    int   k = 0;
    valid     = (exp_pen > 0);
    slv_delay = dly;
    slv_rdata = rd;
    slv_err   = serr;
    CPUWRITE  = wr;
    addr      = a;
    data      = d;
    CPUSEL    = sel;
    APBMASTERENABLE = 1'b1;
    e.rd  = exp_rd;
    e.err = exp_err;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (!keep) APBMASTERENABLE = 1'b0;
    while (!seen && k < 60) begin
      k++;
      @(negedge clk);
      if (PSEL != '0) anysel = 1;
      if (PENABLE) pen++;
      if (PENABLE && (PSEL == '0)) viol = 1;
      if (k == 1 && valid) begin
        check("setup_psel", PSEL, sel);
        check("setup_penable", PENABLE, 0);
        check("setup_paddr", PADDR, a);
        check("setup_pwrite", PWRITE, wr);
        if (wr) check("setup_pwdata", PWDATA, d);
      end
      if (CPUPREADY) begin
        seen = 1;
        check("done_cycle", k + 1, exp_done);
      end
    end
    if (!seen) check("cpupready_seen", 0, 1);
    check("penable_cycles", pen, exp_pen);
    check("psel_activity", anysel, valid);
    check("penable_with_zero_psel", viol, 0);
    if (keep) begin
      CPUWRITE = nx_wr;
      addr     = nx_addr;
      data     = nx_data;
      CPUSEL   = nx_sel;
    end
    @(negedge clk);
    check("cpupready_one_cycle", CPUPREADY, 0);
    check("idle_psel", PSEL, 0);
    check("cpurdata_hold", CPURDATA, exp_rd);
  endtask

  initial begin
    APBRESET        = 1'b1;
    APBMASTERENABLE = 1'b0;
    CPUWRITE        = 1'b0;
    addr            = '0;
    data            = '0;
    CPUSEL          = '0;
    PRDATA          = '0;
    PREADY          = 1'b0;
    PSLVERR         = 1'b0;
    nx_wr = 1'b0; nx_addr = '0; nx_data = '0; nx_sel = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_psel", PSEL, 0);
    check("rst_penable", PENABLE, 0);
    check("rst_pwrite", PWRITE, 0);
    check("rst_paddr", PADDR, 0);
    check("rst_pwdata", PWDATA, 0);
    check("rst_cpupready", CPUPREADY, 0);
    check("rst_cpurdata", CPURDATA, 0);
    check("rst_cpuerr", CPUERR, 0);
    APBRESET = 1'b0;
    @(negedge clk);

    // write, zero-wait slave: CPUPREADY in cycle 4
    do_xfer(1'b1, 8'h03, 21'h3, 8'h01, 0, 21'h0, 1'b0, 21'h0, 1'b0, 4, 1, 0);
    // read, three wait cycles
    do_xfer(1'b0, 8'h0F, 21'h0, 8'h04, 3, 21'h1ABCD, 1'b0, 21'h1ABCD, 1'b0, 7, 4, 0);
    // write answered with PSLVERR; read data register untouched
    do_xfer(1'b1, 8'h55, 21'h12345, 8'h80, 1, 21'h0, 1'b1, 21'h1ABCD, 1'b1, 5, 2, 0);
    // read that never completes: 16 ACCESS cycles, then error with zero data
    do_xfer(1'b0, 8'hA0, 21'h0, 8'h02, -1, 21'h00007, 1'b0, 21'h0, 1'b1, 19, 16, 0);
    // good read to load CPURDATA before the bad-select cases
    do_xfer(1'b0, 8'h21, 21'h0, 8'h10, 0, 21'h0BEEF, 1'b0, 21'h0BEEF, 1'b0, 4, 1, 0);
    // zero select and two-hot select: immediate error, no bus activity
    do_xfer(1'b0, 8'h21, 21'h0, 8'h00, 0, 21'h0BEEF, 1'b0, 21'h0, 1'b1, 2, 0, 0);
    do_xfer(1'b1, 8'h22, 21'h5, 8'h03, 0, 21'h0BEEF, 1'b0, 21'h0, 1'b1, 2, 0, 0);

    // load CPURDATA so the asynchronous reset has something to clear
    do_xfer(1'b0, 8'h30, 21'h0, 8'h01, 0, 21'h1F0F0, 1'b0, 21'h1F0F0, 1'b0, 4, 1, 0);
    // reset in the middle of a stalled write
    slv_delay = -1;
    CPUWRITE = 1'b1; addr = 8'h7E; data = 21'h1FFFF; CPUSEL = 8'h20;
    APBMASTERENABLE = 1'b1;
    @(posedge clk);
    #1;
    APBMASTERENABLE = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_rst_penable", PENABLE, 1);
    #2;
    APBRESET = 1'b1;
    #1;
    check("arst_psel", PSEL, 0);
    check("arst_penable", PENABLE, 0);
    check("arst_pwrite", PWRITE, 0);
    check("arst_paddr", PADDR, 0);
    check("arst_pwdata", PWDATA, 0);
    check("arst_cpupready", CPUPREADY, 0);
    check("arst_cpurdata", CPURDATA, 0);
    check("arst_cpuerr", CPUERR, 0);
    repeat (2) @(negedge clk);
    APBRESET = 1'b0;
    repeat (4) @(negedge clk);
    check("post_rst_psel", PSEL, 0);
    // next request after reset completes normally
    do_xfer(1'b1, 8'h44, 21'h0AAAA, 8'h08, 2, 21'h0, 1'b0, 21'h0, 1'b0, 6, 3, 0);

    // two transfers with the request held high; second sampled in IDLE
    nx_wr = 1'b1; nx_addr = 8'h22; nx_data = 21'h00ABC; nx_sel = 8'h40;
    do_xfer(1'b0, 8'h11, 21'h0, 8'h20, 0, 21'h00321, 1'b0, 21'h00321, 1'b0, 4, 1, 1);
    do_xfer(1'b1, 8'h22, 21'h00ABC, 8'h40, 0, 21'h0, 1'b0, 21'h00321, 1'b0, 4, 1, 0);

    repeat (4) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/apb_master.md
APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 8, address width; DATA_W, default 21, data width; SEL_W, default 8, slave-select width; TIMEOUT, default 16, maximum ACCESS-phase wait cycles.
REQ-002 Port clk  input  1  single clock; all state SHALL change on its rising edge.
REQ-003 Port APBRESET  input  1  reset, asynchronous and active-high.
REQ-004 Port APBMASTERENABLE  input  1  transfer request from the CPU stage.
REQ-005 Port CPUWRITE  input  1  request direction: 1 = write, 0 = read.
REQ-006 Port addr  input  ADDR_W  request address.
REQ-007 Port data  input  DATA_W  request write data.
REQ-008 Port CPUSEL  input  SEL_W  one-hot slave select.
REQ-009 Port CPUPREADY  output  1  one-cycle completion pulse to the CPU.
REQ-010 Port CPURDATA  output  DATA_W  read data returned to the CPU.
REQ-011 Port CPUERR  output  1  error flag, valid while CPUPREADY=1.
REQ-012 Ports PSEL (SEL_W), PENABLE (1), PWRITE (1), PADDR (ADDR_W), PWDATA (DATA_W) SHALL be outputs that drive the APB bus.
REQ-013 Ports PRDATA (DATA_W), PREADY (1), PSLVERR (1) SHALL be inputs from the APB slaves.

Function
REQ-014 FSM states SHALL be IDLE, SETUP, ACCESS and DONE.
REQ-015 IDLE: when APBMASTERENABLE=1 and CPUSEL is one-hot, addr, data, CPUSEL and CPUWRITE SHALL be latched and the next state SHALL be SETUP.
REQ-016 IDLE: when APBMASTERENABLE=1 and CPUSEL is zero or not one-hot, there SHALL be no bus activity; next state DONE with CPUERR=1 and CPURDATA=0.
REQ-017 SETUP: PSEL=latched select, PENABLE=0, and PADDR/PWRITE/PWDATA driven from the latched values; the next state SHALL always be ACCESS.
REQ-018 ACCESS: PENABLE=1, all other bus outputs held stable; the FSM SHALL stay in ACCESS while PREADY=0.
REQ-019 ACCESS with PREADY=1: next state DONE; CPUERR<=PSLVERR; CPURDATA<=PRDATA on a read, CPURDATA unchanged on a write.
REQ-020 ACCESS wait counter: cleared on entry, +1 each cycle with PREADY=0; reaching TIMEOUT SHALL force DONE with CPUERR=1 and CPURDATA=0; the counter SHALL be $clog2(TIMEOUT+1) bits wide.
REQ-021 DONE: CPUPREADY=1 for exactly this one cycle, PSEL=0, PENABLE=0; the next state SHALL be IDLE.
REQ-022 Latency: request sampled at edge N gives SETUP in N+1, ACCESS in N+2, and CPUPREADY in the cycle after PREADY is sampled high (minimum 4 cycles).
REQ-023 APBMASTERENABLE and request inputs SHALL be ignored outside IDLE; a request still held in DONE SHALL start a new transfer from IDLE on the next cycle.
REQ-024 PSEL and PENABLE SHALL never be asserted together with an all-zero PSEL.
REQ-025 CPURDATA SHALL hold its value between transfers.

Reset
REQ-026 APBRESET=1 SHALL immediately force IDLE, PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, CPUPREADY=0, CPURDATA=0, CPUERR=0 and wait counter=0.
REQ-027 Reset during SETUP/ACCESS SHALL abort the transfer with no CPUPREADY pulse; after release the FSM SHALL return to IDLE.

Structure
REQ-028 Package apb_pkg SHALL hold the state enum apb_state_t, the default widths and the TIMEOUT default, shared with the cpu stage.
REQ-029 One sub-module apb_timeout_counter (clear, enable, expired) SHALL implement REQ-020; everything else SHALL be in a single FSM module.

Verification
REQ-030 Write addr=0x03, data=0x3, CPUSEL=0x01, PREADY=1 in the first ACCESS cycle -> PSEL=0x01 in SETUP, PENABLE high for one cycle, CPUPREADY at cycle 4, CPUERR=0.
REQ-031 Read addr=0x0F, CPUSEL=0x04, PREADY delayed 3 cycles, PRDATA=0x1ABCD -> PENABLE high 4 cycles, CPURDATA=0x1ABCD, CPUPREADY one cycle.
REQ-032 Read with PREADY held 0 and TIMEOUT=16 -> after 16 ACCESS cycles CPUPREADY=1, CPUERR=1, CPURDATA=0.
REQ-033 CPUSEL=0x00 and CPUSEL=0x03 -> no PSEL activity, CPUPREADY the next cycle with CPUERR=1.
REQ-034 APBRESET asserted mid-ACCESS -> all outputs 0 asynchronously, no CPUPREADY; the next request completes normally.
REQ-035 APBMASTERENABLE held high across two transfers -> second SETUP begins two cycles after the first CPUPREADY, with addr/data sampled in IDLE.
